// File: rtl/light_source_sequencer.sv
// Light source sequencer: on each accepted sensor trigger, waits a programmed
// delay and then fires one strobe (LED, multi-laser-line or single-laser-line)
// for a programmed width. The light source rotates through up to four slots.
module light_source_sequencer #(
    parameter int CNT_W   = 24,
    parameter int SEQ_MAX = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             frame_start,
    input  logic             cfg_enable,
    input  logic [2:0]       cfg_seq_len,
    input  logic [7:0]       cfg_seq,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    output logic             LEDEn,
    output logic             MLLEn,
    output logic             SLLEn,
    output logic             busy,
    output logic [1:0]       cur_slot,
    output logic             frame_missed,
    output logic             seq_wrap
);

    typedef enum logic [1:0] {IDLE, DELAY, ON} state_t;

    localparam logic [2:0]       SEQ_MAX_L = 3'(SEQ_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] width_lat, width_nx;
    logic [1:0]       code_lat, code_nx;
    logic [2:0]       len_lat, len_nx;
    logic [1:0]       slot_nx;
    logic             led_nx, mll_nx, sll_nx, missed_nx, wrap_nx, busy_nx;
    logic [2:0]       len_eff;
    logic [1:0]       slot_code;
    logic             last_slot;

    // Effective sequence length: 0 counts as one slot, anything above SEQ_MAX clamps.
    always_comb begin
        len_eff = cfg_seq_len;
        if (cfg_seq_len == 3'd0)
            len_eff = 3'd1;
        else if (cfg_seq_len > SEQ_MAX_L)
            len_eff = SEQ_MAX_L;
    end

    // Light source code of the slot about to be used.
    always_comb begin
        slot_code = cfg_seq[1:0];
        case (cur_slot)
            2'd0: slot_code = cfg_seq[1:0];
            2'd1: slot_code = cfg_seq[3:2];
            2'd2: slot_code = cfg_seq[5:4];
            2'd3: slot_code = cfg_seq[7:6];
            default: slot_code = cfg_seq[1:0];
        endcase
    end

    // A slot at or beyond the latched length wraps, so a shrunken length never strands cur_slot.
    assign last_slot = ({1'b0, cur_slot} >= (len_lat - 3'd1));

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        width_nx  = width_lat;
        code_nx   = code_lat;
        len_nx    = len_lat;
        slot_nx   = cur_slot;
        led_nx    = 1'b0;
        mll_nx    = 1'b0;
        sll_nx    = 1'b0;
        missed_nx = 1'b0;
        wrap_nx   = 1'b0;

        if (!cfg_enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            slot_nx  = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state_nx = DELAY;
                        cnt_nx   = cfg_delay;
                        width_nx = cfg_width;
                        code_nx  = slot_code;
                        len_nx   = len_eff;
                    end
                end
                DELAY: begin
                    missed_nx = frame_start;
                    if (cnt == '0) begin
                        if (width_lat == '0) begin
                            // Zero-width frame completes where the strobe would have started.
                            state_nx = IDLE;
                            slot_nx  = last_slot ? 2'd0 : cur_slot + 2'd1;
                            wrap_nx  = last_slot;
                        end else begin
                            state_nx = ON;
                            cnt_nx   = width_lat - CNT_ONE;
                            led_nx   = (code_lat == 2'd1);
                            mll_nx   = (code_lat == 2'd2);
                            sll_nx   = (code_lat == 2'd3);
                        end
                    end else begin
                        cnt_nx = cnt - CNT_ONE;
                    end
                end
                ON: begin
                    missed_nx = frame_start;
                    if (cnt == '0) begin
                        state_nx = IDLE;
                        slot_nx  = last_slot ? 2'd0 : cur_slot + 2'd1;
                        wrap_nx  = last_slot;
                    end else begin
                        cnt_nx = cnt - CNT_ONE;
                        led_nx = (code_lat == 2'd1);
                        mll_nx = (code_lat == 2'd2);
                        sll_nx = (code_lat == 2'd3);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    assign busy_nx = (state_nx != IDLE);

    // State, latched frame parameters and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            width_lat    <= '0;
            code_lat     <= 2'd0;
            len_lat      <= 3'd1;
            cur_slot     <= 2'd0;
            LEDEn        <= 1'b0;
            MLLEn        <= 1'b0;
            SLLEn        <= 1'b0;
            busy         <= 1'b0;
            frame_missed <= 1'b0;
            seq_wrap     <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            width_lat    <= width_nx;
            code_lat     <= code_nx;
            len_lat      <= len_nx;
            cur_slot     <= slot_nx;
            LEDEn        <= led_nx;
            MLLEn        <= mll_nx;
            SLLEn        <= sll_nx;
            busy         <= busy_nx;
            frame_missed <= missed_nx;
            seq_wrap     <= wrap_nx;
        end
    end

endmodule

// File: doc/light_source_sequencer.md
LIGHT_SOURCE_SEQUENCER -- requirements
Module: light_source_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 24, width of delay/width counters.
REQ-002 SHALL have parameter SEQ_MAX, default 4, number of sequence slots (fixed 2-bit slot index).
REQ-003 SHALL have port sys_clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port frame_start, input, 1: one-cycle pulse per sensor trigger.
REQ-006 SHALL have port cfg_enable, input, 1: sequencer enable.
REQ-007 SHALL have port cfg_seq_len, input, 3: active slots; 0 is treated as 1, and values >4 are treated as 4.
REQ-008 SHALL have port cfg_seq, input, 8: slot n code at bits [2n+1:2n]; 0=dark, 1=LED, 2=MLL, 3=SLL.
REQ-009 SHALL have port cfg_delay, input, CNT_W: cycles from accepted frame_start to strobe on.
REQ-010 SHALL have port cfg_width, input, CNT_W: strobe on-time in cycles.
REQ-011 SHALL have port LEDEn, input?no -- output, 1: LED strobe enable.
REQ-012 SHALL have port MLLEn, output, 1: multi-laser-line strobe enable.
REQ-013 SHALL have port SLLEn, output, 1: single-laser-line strobe enable.
REQ-014 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-015 SHALL have port cur_slot, output, 2: index of the slot to be used or in use.
REQ-016 SHALL have port frame_missed, output, 1: one-cycle pulse when frame_start is rejected.
REQ-017 SHALL have port seq_wrap, output, 1: one-cycle pulse when cur_slot wraps to 0.

Function
REQ-018 SHALL implement FSM states IDLE, DELAY, ON; all outputs SHALL be registered.
REQ-019 In IDLE with cfg_enable=1, frame_start at edge k SHALL be accepted.
  - Acceptance latches cfg_delay, cfg_width, the current slot code and the effective sequence length.
  - The FSM moves to DELAY with the counter loaded to cfg_delay.
REQ-020 The strobe SHALL be high from edge k+cfg_delay+1 for exactly cfg_width cycles.
  - cfg_delay=0 gives the strobe high at k+1.
REQ-021 Only the enable selected by the latched code SHALL assert; code 0 (dark) runs the same timing with all enables low.
REQ-022 cfg_width=0 SHALL produce no strobe; the FSM returns to IDLE at the cycle the strobe would have started, with slot advance as in REQ-023.
REQ-023 On leaving ON (or on completion of a zero-width frame), cur_slot SHALL advance by 1.
  - If cur_slot equals the latched length-1, cur_slot SHALL go to 0 and seq_wrap SHALL pulse that same cycle.
REQ-024 At most one of LEDEn, MLLEn, SLLEn SHALL be high in any cycle.
REQ-025 frame_start while busy=1 SHALL be ignored and SHALL pulse frame_missed one cycle later; timing and slot are unaffected.
REQ-026 frame_start on the same cycle the FSM returns to IDLE SHALL be treated as busy and rejected (REQ-025).
REQ-027 frame_start with cfg_enable=0 SHALL be ignored without a frame_missed pulse.
REQ-028 cfg_enable deasserted in any state SHALL, at the next edge, force IDLE, drive all enables low and set cur_slot=0, with no seq_wrap pulse.
REQ-029 Config changes while busy SHALL NOT affect the frame in progress.
REQ-030 Counters SHALL be CNT_W bits and count down without wrap; the maximum values (2^CNT_W-1) SHALL be supported.

Reset
REQ-031 sys_rst=1 at an edge SHALL force IDLE, LEDEn=MLLEn=SLLEn=0, busy=0, cur_slot=0, frame_missed=0, seq_wrap=0, and clear the counters.
REQ-032 Reset mid-strobe SHALL drop the enable at that edge; the first frame_start after reset is accepted as slot 0.

Verification
REQ-033 Basic timing: len=3, seq=LED,MLL,SLL, delay=5, width=10, three frame_starts 40 cycles apart -> LEDEn high cycles k+6..k+15, then MLLEn, then SLLEn; seq_wrap pulses at the end of the SLL frame; cur_slot reads 0.
REQ-034 Zero delay/width: delay=0, width=1 -> strobe is a single cycle at k+1; width=0 -> no strobe, busy for 1 cycle, slot advances.
REQ-035 Overrun: frame_start during ON -> frame_missed pulses once; strobe length unchanged; slot advances only once.
REQ-036 Disable mid-frame: cfg_enable dropped in DELAY -> busy=0 and cur_slot=0 next edge; no strobe; no seq_wrap.
REQ-037 Length clamping and dark slot: seq_len=0 -> slot stays 0 and seq_wrap pulses every frame; seq_len=7 behaves as 4; a code-0 slot gives busy timing with all enables low.
REQ-038 Reset during strobe: sys_rst for 1 cycle while SLLEn=1 -> all outputs 0 next edge; the next frame_start uses slot 0.
